// File: rtl/huffman_detranslation.sv
// Rebuilds literal / (length-3, distance) tokens from static-Huffman symbols; HUFF_DETRANS_STATS_EN adds delivery counters.
// Latency: 3 cycles from input accept to out_valid, 1 token/cycle.
// Backpressure: ready/valid, stall ripples combinationally back to in_ready so a full pipe never bubbles.
module huffman_detranslation #(
    parameter int D_WIDTH   = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8:0]         lit_sym,
    input  logic [4:0]         l_extra,
    input  logic [4:0]         d_sym,
    input  logic [12:0]        d_extra,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         l_V,
    output logic [D_WIDTH-1:0] d_V,
    output logic               eob,
    output logic               err
`ifdef HUFF_DETRANS_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] lit_count,
    output logic [CNT_WIDTH-1:0] match_count
`endif
);

    typedef enum logic [1:0] {CLS_LIT, CLS_EOB, CLS_LEN, CLS_BAD} sym_class_t;

    // {l_base[7:0], l_nbits[2:0]} indexed by lit_sym-257
    function automatic logic [10:0] len_rom(input logic [8:0] a);
        logic [10:0] t;
        t = '0;
        case (a)
            9'd0:  t = {8'd0,   3'd0};
            9'd1:  t = {8'd1,   3'd0};
            9'd2:  t = {8'd2,   3'd0};
            9'd3:  t = {8'd3,   3'd0};
            9'd4:  t = {8'd4,   3'd0};
            9'd5:  t = {8'd5,   3'd0};
            9'd6:  t = {8'd6,   3'd0};
            9'd7:  t = {8'd7,   3'd0};
            9'd8:  t = {8'd8,   3'd1};
            9'd9:  t = {8'd10,  3'd1};
            9'd10: t = {8'd12,  3'd1};
            9'd11: t = {8'd14,  3'd1};
            9'd12: t = {8'd16,  3'd2};
            9'd13: t = {8'd20,  3'd2};
            9'd14: t = {8'd24,  3'd2};
            9'd15: t = {8'd28,  3'd2};
            9'd16: t = {8'd32,  3'd3};
            9'd17: t = {8'd40,  3'd3};
            9'd18: t = {8'd48,  3'd3};
            9'd19: t = {8'd56,  3'd3};
            9'd20: t = {8'd64,  3'd4};
            9'd21: t = {8'd80,  3'd4};
            9'd22: t = {8'd96,  3'd4};
            9'd23: t = {8'd112, 3'd4};
            9'd24: t = {8'd128, 3'd5};
            9'd25: t = {8'd160, 3'd5};
            9'd26: t = {8'd192, 3'd5};
            9'd27: t = {8'd224, 3'd5};
            9'd28: t = {8'd255, 3'd0};
            default: t = '0;
        endcase
        return t;
    endfunction

    // {d_base[15:0], d_nbits[3:0]} indexed by d_sym
    function automatic logic [19:0] dist_rom(input logic [4:0] a);
        logic [19:0] t;
        t = '0;
        case (a)
            5'd0:  t = {16'd1,     4'd0};
            5'd1:  t = {16'd2,     4'd0};
            5'd2:  t = {16'd3,     4'd0};
            5'd3:  t = {16'd4,     4'd0};
            5'd4:  t = {16'd5,     4'd1};
            5'd5:  t = {16'd7,     4'd1};
            5'd6:  t = {16'd9,     4'd2};
            5'd7:  t = {16'd13,    4'd2};
            5'd8:  t = {16'd17,    4'd3};
            5'd9:  t = {16'd25,    4'd3};
            5'd10: t = {16'd33,    4'd4};
            5'd11: t = {16'd49,    4'd4};
            5'd12: t = {16'd65,    4'd5};
            5'd13: t = {16'd97,    4'd5};
            5'd14: t = {16'd129,   4'd6};
            5'd15: t = {16'd193,   4'd6};
            5'd16: t = {16'd257,   4'd7};
            5'd17: t = {16'd385,   4'd7};
            5'd18: t = {16'd513,   4'd8};
            5'd19: t = {16'd769,   4'd8};
            5'd20: t = {16'd1025,  4'd9};
            5'd21: t = {16'd1537,  4'd9};
            5'd22: t = {16'd2049,  4'd10};
            5'd23: t = {16'd3073,  4'd10};
            5'd24: t = {16'd4097,  4'd11};
            5'd25: t = {16'd6145,  4'd11};
            5'd26: t = {16'd8193,  4'd12};
            5'd27: t = {16'd12289, 4'd12};
            5'd28: t = {16'd16385, 4'd13};
            5'd29: t = {16'd24577, 4'd13};
            default: t = '0;
        endcase
        return t;
    endfunction

    logic        v1, v2, adv1, adv2;
    sym_class_t  cls_in, cls1, cls2;
    logic [7:0]  lit1, lit2;
    logic [8:0]  l_addr1;
    logic [4:0]  d_addr1;
    logic [4:0]  l_extra1, l_extra2;
    logic [12:0] d_extra1, d_extra2;
    logic [7:0]  l_base2;
    logic [2:0]  l_nbits2;
    logic [15:0] d_base2;
    logic [3:0]  d_nbits2;
    logic [7:0]  l_mask, l_sum;
    logic [12:0] d_mask;
    logic [16:0] d_sum;

    assign adv2     = !out_valid | out_ready;
    assign adv1     = !v2 | adv2;
    assign in_ready = !v1 | adv1;

    always_comb begin
        cls_in = CLS_LIT;
        if (lit_sym == 9'd256) begin
            cls_in = CLS_EOB;
        end else if (lit_sym > 9'd256) begin
            cls_in = (lit_sym > 9'd285 || d_sym > 5'd29) ? CLS_BAD : CLS_LEN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1       <= 1'b0;
            cls1     <= CLS_LIT;
            lit1     <= '0;
            l_addr1  <= '0;
            d_addr1  <= '0;
            l_extra1 <= '0;
            d_extra1 <= '0;
        end else if (in_ready) begin
            v1       <= in_valid;
            cls1     <= cls_in;
            lit1     <= lit_sym[7:0];
            l_addr1  <= lit_sym - 9'd257;
            d_addr1  <= d_sym;
            l_extra1 <= l_extra;
            d_extra1 <= d_extra;
        end
    end

    // Table ROMs only read on advance, so their output doubles as the stage-2 hold register.
    always_ff @(posedge clk) begin
        if (adv1) begin
            {l_base2, l_nbits2} <= len_rom(l_addr1);
            {d_base2, d_nbits2} <= dist_rom(d_addr1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2       <= 1'b0;
            cls2     <= CLS_LIT;
            lit2     <= '0;
            l_extra2 <= '0;
            d_extra2 <= '0;
        end else if (adv1) begin
            v2       <= v1;
            cls2     <= cls1;
            lit2     <= lit1;
            l_extra2 <= l_extra1;
            d_extra2 <= d_extra1;
        end
    end

    // Extra bits above nbits are silently dropped.
    assign l_mask = ~(8'hFF << l_nbits2);
    assign d_mask = ~(13'h1FFF << d_nbits2);
    assign l_sum  = l_base2 + ({3'b000, l_extra2} & l_mask);
    assign d_sum  = {1'b0, d_base2} + {4'b0000, d_extra2 & d_mask};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            l_V       <= '0;
            d_V       <= '0;
            eob       <= 1'b0;
            err       <= 1'b0;
        end else if (adv2) begin
            out_valid <= v2;
            l_V       <= '0;
            d_V       <= '0;
            eob       <= 1'b0;
            err       <= 1'b0;
            case (cls2)
                CLS_LIT: l_V <= lit2;
                CLS_LEN: begin
                    l_V <= l_sum;
                    d_V <= D_WIDTH'(d_sum);
                end
                CLS_EOB: eob <= 1'b1;
                CLS_BAD: err <= 1'b1;
                default: err <= 1'b1;
            endcase
        end
    end

`ifdef HUFF_DETRANS_STATS_EN
    // Matches always carry a non-zero distance, literals carry zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lit_count   <= '0;
            match_count <= '0;
        end else if (out_valid && out_ready && !eob && !err) begin
            if (d_V == '0) begin
                if (lit_count != '1) lit_count <= lit_count + CNT_WIDTH'(1);
            end else begin
                if (match_count != '1) match_count <= match_count + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_huffman_detranslation.sv
// Directed self-checking bench for huffman_detranslation; counter checks compiled in with HUFF_DETRANS_STATS_EN.
`timescale 1ns/1ps
module tb_huffman_detranslation;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [8:0]  lit_sym;
    logic [4:0]  l_extra, d_sym;
    logic [12:0] d_extra;
    logic [7:0]  l_V;
    logic [15:0] d_V;
    logic        eob, err;
`ifdef HUFF_DETRANS_STATS_EN
    logic [31:0] lit_count, match_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [8:0]  ls;
        logic [4:0]  le;
        logic [4:0]  ds;
        logic [12:0] de;
        logic [7:0]  el;
        logic [15:0] ed;
        logic        ee;
        logic        eer;
    } vec_t;

    always #5 clk = ~clk;

    huffman_detranslation #(.D_WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .lit_sym(lit_sym),
        .l_extra(l_extra),
        .d_sym(d_sym),
        .d_extra(d_extra),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .l_V(l_V),
        .d_V(d_V),
        .eob(eob),
        .err(err)
`ifdef HUFF_DETRANS_STATS_EN
        ,
        .lit_count(lit_count),
        .match_count(match_count)
`endif
    );

    // Sends one token into an idle pipe and waits (bounded) for it at the output.
    task automatic run_one(input vec_t v, output logic [25:0] got, output int lat);
        @(negedge clk);
        lit_sym = v.ls; l_extra = v.le; d_sym = v.ds; d_extra = v.de;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        got = {l_V, d_V, eob, err};
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, l_V, d_V, eob, err} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {out_valid, l_V, d_V, eob, err});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
`ifdef HUFF_DETRANS_STATS_EN
        checks++;
        if ({lit_count, match_count} !== 64'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", lit_count, match_count);
        end
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_literal();
        vec_t tv[3];
        logic [25:0] got;
        int lat;
        tv[0] = '{9'h041, 5'd0,  5'd0,  13'd0,    8'h41, 16'd0, 1'b0, 1'b0};
        tv[1] = '{9'h000, 5'd31, 5'd31, 13'd8191, 8'h00, 16'd0, 1'b0, 1'b0};
        tv[2] = '{9'h0FF, 5'd0,  5'd5,  13'd0,    8'hFF, 16'd0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_one(tv[i], got, lat);
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL literal%0d_latency got=%0d exp=3", i, lat);
            end
            checks++;
            if (got !== {tv[i].el, tv[i].ed, tv[i].ee, tv[i].eer}) begin
                failures++;
                $display("FAIL literal%0d_token got=%h exp=%h", i, got,
                         {tv[i].el, tv[i].ed, tv[i].ee, tv[i].eer});
            end
        end
    endtask

    task automatic test_match();
        vec_t tv[6];
        logic [25:0] got;
        int lat;
        tv[0] = '{9'd265, 5'd1,  5'd4,  13'd1,    8'd9,   16'd6,     1'b0, 1'b0};
        tv[1] = '{9'd285, 5'd0,  5'd29, 13'd8191, 8'd255, 16'd32768, 1'b0, 1'b0};
        tv[2] = '{9'd257, 5'd0,  5'd0,  13'd0,    8'd0,   16'd1,     1'b0, 1'b0};
        tv[3] = '{9'd265, 5'd31, 5'd4,  13'd8191, 8'd9,   16'd6,     1'b0, 1'b0};
        tv[4] = '{9'd270, 5'd3,  5'd13, 13'h025,  8'd23,  16'd102,   1'b0, 1'b0};
        tv[5] = '{9'd284, 5'd31, 5'd28, 13'd0,    8'd255, 16'd16385, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_one(tv[i], got, lat);
            checks++;
            if (got !== {tv[i].el, tv[i].ed, tv[i].ee, tv[i].eer} || lat !== 3) begin
                failures++;
                $display("FAIL match%0d_token got=%h lat=%0d exp=%h lat=3", i, got, lat,
                         {tv[i].el, tv[i].ed, tv[i].ee, tv[i].eer});
            end
        end
    endtask

    task automatic test_eob_err();
        vec_t tv[6];
        logic [25:0] got;
        int lat;
        tv[0] = '{9'd256, 5'd0, 5'd0,  13'd0, 8'd0, 16'd0, 1'b1, 1'b0};
        tv[1] = '{9'd256, 5'd7, 5'd31, 13'd5, 8'd0, 16'd0, 1'b1, 1'b0};
        tv[2] = '{9'd286, 5'd0, 5'd0,  13'd0, 8'd0, 16'd0, 1'b0, 1'b1};
        tv[3] = '{9'd287, 5'd0, 5'd0,  13'd0, 8'd0, 16'd0, 1'b0, 1'b1};
        tv[4] = '{9'd260, 5'd0, 5'd31, 13'd0, 8'd0, 16'd0, 1'b0, 1'b1};
        tv[5] = '{9'd260, 5'd0, 5'd30, 13'd0, 8'd0, 16'd0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_one(tv[i], got, lat);
            checks++;
            if (got !== {tv[i].el, tv[i].ed, tv[i].ee, tv[i].eer} || lat !== 3) begin
                failures++;
                $display("FAIL eoberr%0d_token got=%h lat=%0d exp=%h lat=3", i, got, lat,
                         {tv[i].el, tv[i].ed, tv[i].ee, tv[i].eer});
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t tv[6];
        int sent = 0, recv = 0, first_block = -1, extra = 0;
        logic stalled = 1'b0;
        logic [25:0] held = '0;
        logic ir;
        tv[0] = '{9'h010, 5'd0, 5'd0, 13'd0, 8'h10, 16'd0, 1'b0, 1'b0};
        tv[1] = '{9'd266, 5'd0, 5'd5, 13'd1, 8'd10,  16'd8, 1'b0, 1'b0};
        tv[2] = '{9'h020, 5'd0, 5'd0, 13'd0, 8'h20, 16'd0, 1'b0, 1'b0};
        tv[3] = '{9'd256, 5'd0, 5'd0, 13'd0, 8'd0,  16'd0, 1'b1, 1'b0};
        tv[4] = '{9'd285, 5'd0, 5'd1, 13'd0, 8'd255, 16'd2, 1'b0, 1'b0};
        tv[5] = '{9'h030, 5'd0, 5'd0, 13'd0, 8'h30, 16'd0, 1'b0, 1'b0};
        for (int c = 0; c < 40 && recv < 6; c++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if ({out_valid, l_V, d_V, eob, err} !== {1'b1, held}) begin
                    failures++;
                    $display("FAIL b2b_stable cycle=%0d got=%h exp=%h", c,
                             {out_valid, l_V, d_V, eob, err}, {1'b1, held});
                end
            end
            out_ready = !(c >= 2 && c <= 7);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                lit_sym = tv[sent].ls; l_extra = tv[sent].le;
                d_sym   = tv[sent].ds; d_extra = tv[sent].de;
            end
            #1;
            ir = in_ready;
            if (!ir && first_block < 0) begin
                first_block = c;
                checks++;
                if (sent - recv !== 3) begin
                    failures++;
                    $display("FAIL b2b_held_when_blocked got=%0d exp=3", sent - recv);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({l_V, d_V, eob, err} !== {tv[recv].el, tv[recv].ed, tv[recv].ee, tv[recv].eer}) begin
                    failures++;
                    $display("FAIL b2b_token%0d got=%h exp=%h", recv, {l_V, d_V, eob, err},
                             {tv[recv].el, tv[recv].ed, tv[recv].ee, tv[recv].eer});
                end
                recv++;
            end
            if (in_valid && ir) sent++;
            stalled = out_valid && !out_ready;
            held    = {l_V, d_V, eob, err};
        end
        in_valid = 1'b0;
        checks++;
        if (recv !== 6) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=6", recv);
        end
        checks++;
        if (first_block < 0) begin
            failures++;
            $display("FAIL b2b_backpressure got=none exp=in_ready_low");
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL b2b_duplicates got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_inflight();
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        lit_sym = 9'h055; l_extra = '0; d_sym = '0; d_extra = '0;
        @(negedge clk);
        lit_sym = 9'd257;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_precondition_out_valid got=%b exp=1", out_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, l_V, d_V, eob, err, in_ready} !== 28'd1) begin
            failures++;
            $display("FAIL rst_inflight_clear got=%h exp=1", {out_valid, l_V, d_V, eob, err, in_ready});
        end
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL rst_stale_token got=%0d exp=0", stale);
        end
`ifdef HUFF_DETRANS_STATS_EN
        checks++;
        if ({lit_count, match_count} !== 64'd0) begin
            failures++;
            $display("FAIL rst_counters got=%0d/%0d exp=0/0", lit_count, match_count);
        end
`endif
    endtask

`ifdef HUFF_DETRANS_STATS_EN
    task automatic test_stats();
        vec_t tv[7];
        logic [25:0] got;
        int lat;
        tv[0] = '{9'h061, 5'd0, 5'd0,  13'd0, 8'h61, 16'd0, 1'b0, 1'b0};
        tv[1] = '{9'd258, 5'd0, 5'd2,  13'd0, 8'd1,  16'd3, 1'b0, 1'b0};
        tv[2] = '{9'h062, 5'd0, 5'd0,  13'd0, 8'h62, 16'd0, 1'b0, 1'b0};
        tv[3] = '{9'd256, 5'd0, 5'd0,  13'd0, 8'd0,  16'd0, 1'b1, 1'b0};
        tv[4] = '{9'd286, 5'd0, 5'd0,  13'd0, 8'd0,  16'd0, 1'b0, 1'b1};
        tv[5] = '{9'd259, 5'd0, 5'd0,  13'd0, 8'd2,  16'd1, 1'b0, 1'b0};
        tv[6] = '{9'h063, 5'd0, 5'd0,  13'd0, 8'h63, 16'd0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) run_one(tv[i], got, lat);
        @(negedge clk);
        checks++;
        if (lit_count !== 32'd3) begin
            failures++;
            $display("FAIL stats_lit_count got=%0d exp=3", lit_count);
        end
        checks++;
        if (match_count !== 32'd2) begin
            failures++;
            $display("FAIL stats_match_count got=%0d exp=2", match_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        lit_sym = '0; l_extra = '0; d_sym = '0; d_extra = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_literal();
        test_match();
        test_eob_err();
        test_back_to_back();
        test_reset_inflight();
`ifdef HUFF_DETRANS_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
